pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The module SHALL have parameter SEG_W, default 8, meaning bits added per pipeline stage.
REQ-003 The module SHALL have ports, one per line:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  adder can accept a beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  unsigned carry-out; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Function
REQ-004 The module SHALL assert an error at elaboration if WIDTH is not a nonzero multiple of SEG_W. STAGES SHALL equal WIDTH/SEG_W.
REQ-005 Each accepted beat SHALL compute a + b + cin when sub=0, and a + ~b + 1 when sub=1. The result SHALL be modulo 2^WIDTH.
REQ-006 Stage k (0..STAGES-1) SHALL add bits [k*SEG_W +: SEG_W] using the registered carry from stage k-1. Stage 0 SHALL use the effective carry-in.
REQ-007 Operand bits not yet consumed and sum bits already produced SHALL travel with their beat in the pipeline registers (skew/deskew).
REQ-008 Latency SHALL be exactly STAGES cycles from the acceptance edge to out_valid, absent stalls.
REQ-009 A beat SHALL be accepted on a rising edge with in_valid && in_ready.
REQ-010 A result SHALL be consumed on a rising edge with out_valid && out_ready.
REQ-011 in_ready SHALL equal !(out_valid && !out_ready). This is a global stall: while stalled, every stage holds its contents.
REQ-012 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-013 While out_valid is high and out_ready is low, sum, cout and overflow SHALL be held stable.
REQ-014 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-015 Results SHALL exit in acceptance order, with no loss or duplication.
REQ-016 Pipeline bubbles (in_valid low) SHALL propagate as invalid stages and SHALL NOT produce out_valid.
REQ-017 Simultaneous consume and accept on the same edge SHALL be legal, with no lost cycle.
REQ-018 in_valid asserted during a stall SHALL NOT be accepted. The upstream stage SHALL hold its beat.

Reset
REQ-019 On rst high, all stage valid bits SHALL clear immediately (asynchronously), and out_valid SHALL go to 0.
REQ-020 While rst is high, in_ready SHALL be 1. sum, cout and overflow SHALL be 0.
REQ-021 Beats in flight at reset SHALL be discarded and SHALL never appear after release.
REQ-022 The first beat SHALL be acceptable on the first clock edge after rst deasserts.

Structure
REQ-023 Default WIDTH/SEG_W constants and the add/subtract mode encoding SHALL live in the shared package adder_pkg.
REQ-024 The per-stage combinational SEG_W-bit ripple adder SHALL be a sub-module adder_segment (ports a, b, cin, sum, cout, cmsb). cmsb is the carry into the top bit.
REQ-025 Stage registers SHALL be generated with a generate loop over STAGES. There SHALL be no combinational path from in_valid to out_valid.

Verification (WIDTH=32, SEG_W=8 unless noted)
REQ-026 a=0xFFFFFFFF, b=0x1, cin=0, sub=0 -> sum=0x00000000, cout=1, overflow=0, out_valid exactly 4 cycles after acceptance.
REQ-027 a=0x7FFFFFFF, b=0x1, cin=0, sub=0 -> sum=0x80000000, cout=0, overflow=1.
REQ-028 a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, overflow=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-029 Four back-to-back beats with out_ready low for 3 cycles after the first result -> in_ready low during the stall, first result stable, all four results correct and in order, none dropped.
REQ-030 rst pulsed with 3 beats in flight -> out_valid low immediately, and no result emerges after release.
REQ-031 WIDTH=12, SEG_W=4: a=0xFFF, b=0x001 -> sum=0x000, cout=1, latency 3 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder: default geometry and the
// add/subtract mode encoding.
package adder_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SEG_W_DEF = 8;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/adder_segment.sv
// Combinational W-bit ripple-carry slice; cmsb is the carry into the top bit
// so the last slice can derive signed overflow.
module adder_segment #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  always_comb begin
    logic carry;
    sum   = '0;
    cmsb  = cin;
    carry = cin;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) cmsb = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Segmented add/subtract pipeline: an input capture rank followed by one rank
// per SEG_W-bit slice, all ranks advancing together under a global stall.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STAGES = (SEG_W > 0) ? WIDTH / SEG_W : 1;

  if (SEG_W <= 0 || WIDTH <= 0 || (WIDTH % SEG_W) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH (%0d) must be a nonzero multiple of SEG_W (%0d)",
           WIDTH, SEG_W);
  end

  // Each beat carries its full operands and partial sum; untouched bits
  // simply ride along until their slice is reached.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ov;
  } beat_t;

  beat_t st [STAGES+1];
  mode_e mode;
  logic  adv;

  assign mode     = mode_e'(sub);
  assign in_ready = !(out_valid && !out_ready);
  assign adv      = in_ready;

  beat_t in_d, in_q;

  always_comb begin
    in_d     = '0;
    in_d.vld = in_valid;
    in_d.a   = a;
    in_d.b   = (mode == MODE_SUB) ? ~b : b;
    in_d.c   = (mode == MODE_SUB) ? 1'b1 : cin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      in_q <= '0;
    else if (adv) in_q <= in_d;
  end

  assign st[0] = in_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG_W-1:0] seg_sum;
    logic             seg_cout;
    logic             seg_cmsb;
    beat_t            st_d, st_q;

    adder_segment #(.W(SEG_W)) u_seg (
      .a    (st[k].a[k*SEG_W +: SEG_W]),
      .b    (st[k].b[k*SEG_W +: SEG_W]),
      .cin  (st[k].c),
      .sum  (seg_sum),
      .cout (seg_cout),
      .cmsb (seg_cmsb)
    );

    // ov is only meaningful once the MSB slice has been added
    always_comb begin
      st_d                       = st[k];
      st_d.s[k*SEG_W +: SEG_W]   = seg_sum;
      st_d.c                     = seg_cout;
      st_d.ov                    = seg_cmsb ^ seg_cout;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)      st_q <= '0;
      else if (adv) st_q <= st_d;
    end

    assign st[k+1] = st_q;
  end

  assign out_valid = st[STAGES].vld;
  assign sum       = st[STAGES].s;
  assign cout      = st[STAGES].c;
  assign overflow  = st[STAGES].ov;

endmodule
